// File: rtl/product_bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : product_bcd_display_pkg
// Purpose  : Shared types and constants for the product BCD display block:
//            handshake FSM encoding, BCD geometry, seven-segment patterns.
// Revision : 1.0 - initial release
// ============================================================================
package product_bcd_display_pkg;

  localparam int BCD_NIBBLE_W = 4;
  localparam int BCD_DIGITS   = 3;
  localparam int BCD_W        = BCD_NIBBLE_W * BCD_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n holds the pattern for decimal digit n
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Non-decimal nibbles never occur from the converter; show them as blank
  function automatic logic [6:0] seg7_encode(input logic [BCD_NIBBLE_W-1:0] nibble);
    logic [6:0] pattern;
    pattern = SEG_BLANK;
    if (nibble <= 4'd9) pattern = SEG_DIGITS[nibble];
    return pattern;
  endfunction

endpackage
`default_nettype wire

// File: rtl/product_bcd_display_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : product_bcd_display_seg7_scan
// Purpose  : Time-multiplexed 4-digit common-anode scan of a 3-digit BCD
//            value with leading-zero blanking and registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module product_bcd_display_seg7_scan
  import product_bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] bcd,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] r_refresh;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic [6:0]       w_seg_next;
  logic [3:0]       w_hund;
  logic [3:0]       w_tens;
  logic [3:0]       w_ones;
  logic             w_wrap;

  assign w_hund = bcd[11:8];
  assign w_tens = bcd[7:4];
  assign w_ones = bcd[3:0];
  assign w_wrap = (r_refresh == CNT_W'(REFRESH_DIV - 1));

  // Slot timer: advance the digit index once per REFRESH_DIV cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
    end else if (w_wrap) begin
      r_refresh <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_refresh <= r_refresh + CNT_W'(1);
    end
  end

  // Pick the digit for the current slot, blanking leading zeros
  always_comb begin
    w_seg_next = SEG_BLANK;
    case (r_idx)
      2'd0: w_seg_next = seg7_encode(w_ones);
      2'd1: if (!(w_hund == 4'd0 && w_tens == 4'd0)) w_seg_next = seg7_encode(w_tens);
      2'd2: if (w_hund != 4'd0) w_seg_next = seg7_encode(w_hund);
      default: w_seg_next = SEG_BLANK;
    endcase
  end

  // Register the pins so they change cleanly one cycle after the index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 4'b1110;
      r_seg <= SEG_DIGITS[0];
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
`default_nettype wire

// File: rtl/product_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : product_bcd_display
// Purpose  : Accepts a binary product over a valid/ready handshake, converts
//            it to BCD with a one-bit-per-cycle double-dabble engine and
//            drives a multiplexed seven-segment display with the result.
// Revision : 1.0 - initial release
// ============================================================================
module product_bcd_display
  import product_bcd_display_pkg::*;
#(
  parameter int IN_W        = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic [BCD_W-1:0] bcd,
  output logic             bcd_valid,
  output logic             busy,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int SR_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  w_sr_adj;
  logic [SR_W-1:0]  w_sr_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [BCD_W-1:0] r_bcd;
  logic             r_bcd_valid;
  logic             w_last;

  assign w_last = (r_bit_cnt == CNT_W'(1));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next state: IDLE waits for a transfer, SHIFT runs IN_W steps, DONE is one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last)   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
  always_comb begin
    w_sr_adj = r_sr;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r_sr[IN_W + BCD_NIBBLE_W*d +: BCD_NIBBLE_W] >= 4'd5)
        w_sr_adj[IN_W + BCD_NIBBLE_W*d +: BCD_NIBBLE_W] =
          r_sr[IN_W + BCD_NIBBLE_W*d +: BCD_NIBBLE_W] + 4'd3;
    end
    w_sr_next = w_sr_adj << 1;
  end

  // Shift register, bit counter and result hold register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sr      <= {{BCD_W{1'b0}}, in_data};
            r_bit_cnt <= CNT_W'(IN_W);
          end
        end
        S_SHIFT: begin
          r_sr      <= w_sr_next;
          r_bit_cnt <= r_bit_cnt - CNT_W'(1);
          if (w_last) begin
            r_bcd       <= w_sr_next[SR_W-1:IN_W];
            r_bcd_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign bcd       = r_bcd;
  assign bcd_valid = r_bcd_valid;

  product_bcd_display_seg7_scan #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_seg7_scan (
    .clk (clk),
    .rst (rst),
    .bcd (r_bcd),
    .an  (an),
    .seg (seg)
  );

endmodule
`default_nettype wire

// File: tb/tb_product_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_bcd_display
// Purpose  : Self-checking bench for product_bcd_display against a decimal
//            arithmetic reference model, plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_bcd_display;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;

  // Reference model state: conversion countdown, latest value, display timing
  int         m_cnt = 0;
  int         m_bcd = 0;
  int         m_pending = 0;
  int         m_edges = 0;
  bit         m_valid = 1'b0;
  logic [3:0] m_an = 4'b1110;
  logic [6:0] m_seg = 7'h40;

  product_bcd_display #(
    .IN_W        (8),
    .REFRESH_DIV (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int v, input int idx);
    int h, t, o;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    case (idx)
      0: return pat(o);
      1: return (h == 0 && t == 0) ? 7'h7F : pat(t);
      2: return (h == 0) ? 7'h7F : pat(h);
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Model: a transfer starts a 9-edge busy window; the result appears on the 8th edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_bcd = 0; m_valid = 1'b0; m_edges = 0;
      m_an = 4'b1110; m_seg = 7'h40;
    end else begin
      m_an  = ~(4'b0001 << ((m_edges / D) % 4));
      m_seg = seg_of(m_bcd, (m_edges / D) % 4);
      m_edges++;
      if (m_cnt == 0) begin
        if (in_valid) begin
          m_pending = int'(in_data);
          m_cnt = 9;
        end
      end else begin
        m_cnt--;
      end
      m_valid = (m_cnt == 1);
      if (m_valid) m_bcd = m_pending;
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready",  in_ready,  m_cnt == 0);
      check("busy",      busy,      m_cnt != 0);
      check("bcd",       bcd,       to_bcd(m_bcd));
      check("bcd_valid", bcd_valid, m_valid);
      check("an",        an,        m_an);
      check("seg",       seg,       m_seg);
      if (bcd_valid) n_pulse++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (m_cnt != 0 && k < 40) begin
      step();
      k++;
    end
    if (k >= 40) timeout_fail("wait_ready");
  endtask

  task automatic send(input logic [7:0] v);
    wait_ready();
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!bcd_valid && cycles < 30);
    if (!bcd_valid) timeout_fail("wait_valid");
  endtask

  task automatic scan_check(input string name, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2);
    logic [3:0] seen;
    seen = 4'b0000;
    repeat (2) step();
    repeat (4 * D) begin
      case (an)
        4'b1110: begin check({name, "_d0"}, seg, s0);    seen[0] = 1'b1; end
        4'b1101: begin check({name, "_d1"}, seg, s1);    seen[1] = 1'b1; end
        4'b1011: begin check({name, "_d2"}, seg, s2);    seen[2] = 1'b1; end
        4'b0111: begin check({name, "_d3"}, seg, 7'h7F); seen[3] = 1'b1; end
        default: check({name, "_an"}, an, 4'b1110);
      endcase
      step();
    end
    check({name, "_seen"}, seen, 4'b1111);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"},  in_ready,  1'b1);
    check({name, "_busy"},      busy,      1'b0);
    check({name, "_bcd"},       bcd,       12'h000);
    check({name, "_bcd_valid"}, bcd_valid, 1'b0);
    check({name, "_an"},        an,        4'b1110);
    check({name, "_seg"},       seg,       7'h40);
  endtask

  initial begin
    int c, c2, p0;
    #2 rst = 1'b0;
    #1 check_reset_values("reset");
    step();
    step();
    rst = 1'b1;
    step();

    // Zero: latency 8 edges after accept, only the ones digit lit
    send(8'd0);
    wait_valid(c);
    check("lat_0", c, 8);
    check("bcd_0", bcd, 12'h000);
    scan_check("scan_0", 7'h40, 7'h7F, 7'h7F);

    send(8'd225);
    wait_valid(c);
    check("bcd_225", bcd, 12'h225);
    scan_check("scan_225", 7'h12, 7'h24, 7'h24);

    send(8'd128);
    wait_valid(c);
    check("bcd_128", bcd, 12'h128);

    send(8'd7);
    wait_valid(c);
    check("bcd_7", bcd, 12'h007);
    scan_check("scan_7", 7'h78, 7'h7F, 7'h7F);

    // Held valid: second value must wait for the converter to go idle
    wait_ready();
    in_valid = 1'b1;
    in_data  = 8'd9;
    step();
    in_data  = 8'd49;
    wait_valid(c);
    check("bcd_9", bcd, 12'h009);
    wait_valid(c2);
    check("b2b_gap", c2, 10);
    check("bcd_49", bcd, 12'h049);
    in_valid = 1'b0;

    // Reset in the middle of a conversion discards it
    send(8'd200);
    repeat (3) step();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("midreset");
    step();
    step();
    rst = 1'b1;
    p0 = n_pulse;
    repeat (15) step();
    check("no_pulse_after_reset", n_pulse - p0, 0);
    send(8'd99);
    wait_valid(c);
    check("bcd_99", bcd, 12'h099);

    // Full sweep with random idle gaps: one pulse per transfer
    p0 = n_pulse;
    for (int v = 0; v < 256; v++) begin
      send(8'(v));
      repeat ($urandom_range(0, 2)) step();
    end
    wait_ready();
    step();
    check("sweep_pulses", n_pulse - p0, 256);

    // Random valid/data traffic, including values changing while busy
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
